// File: rtl/rsa_pkg.sv
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared types and constants for the Montgomery RSA datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rsa_pkg;

    localparam int BIT_LEN = 64;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SQR  = 3'd2,
        S_MUL  = 3'd3,
        S_CONV = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Wide enough to hold the value bitLen itself, not just bitLen-1.
    function automatic int cnt_width(input int bl);
        return $clog2(bl) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mon_pro.sv
// ============================================================================
//  Module      : mon_pro
//  Description : Radix-2 bit-serial Montgomery product t = a*b*R^-1 mod n.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mon_pro
    import rsa_pkg::*;
#(
    parameter int bitLen = BIT_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [bitLen-1:0] a_i,
    input  logic [bitLen-1:0] b_i,
    input  logic [bitLen-1:0] n_i,
    output logic [bitLen-1:0] t_o,
    output logic              done_o
);

    localparam int CW = cnt_width(bitLen);
    localparam int DW = bitLen + 2;

    logic              busy_q;
    logic [CW-1:0]     cnt_q;
    logic [bitLen-1:0] a_q;
    logic [bitLen-1:0] b_q;
    logic [bitLen-1:0] n_q;
    logic [DW-1:0]     t_q;

    logic [DW-1:0]     w_n_ext;
    logic [DW-1:0]     w_sum;
    logic [DW-1:0]     w_red;
    logic [DW-1:0]     w_fin;
    logic              w_unused;

    assign w_n_ext  = {2'b00, n_q};
    assign w_sum    = t_q + (a_q[0] ? {2'b00, b_q} : '0);
    assign w_red    = w_sum[0] ? (w_sum + w_n_ext) : w_sum;
    // Final conditional subtraction is combinational so the result is usable in the done cycle.
    assign w_fin    = (t_q >= w_n_ext) ? (t_q - w_n_ext) : t_q;
    assign t_o      = w_fin[bitLen-1:0];
    assign w_unused = ^w_fin[DW-1:bitLen];
    assign done_o   = busy_q && (cnt_q == CW'(bitLen));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            t_q    <= '0;
        end else if (start_i && (!busy_q || done_o)) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            a_q    <= a_i;
            b_q    <= b_i;
            n_q    <= n_i;
            t_q    <= '0;
        end else if (busy_q) begin
            if (cnt_q == CW'(bitLen)) begin
                busy_q <= 1'b0;
            end else begin
                t_q   <= w_red >> 1;
                a_q   <= a_q >> 1;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mon_exp.sv
// ============================================================================
//  Module      : mon_exp
//  Description : Left-to-right Montgomery modular exponentiator, ans = M^e mod n.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mon_exp
    import rsa_pkg::*;
#(
    parameter int bitLen = BIT_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [bitLen-1:0] M_bar,
    input  logic [bitLen-1:0] x_bar,
    input  logic [bitLen-1:0] e,
    input  logic [bitLen-1:0] n,
    output logic              stop,
    output logic [bitLen:0]   ans
);

    localparam int IW = $clog2(bitLen);

    state_t            state_q;
    state_t            op_d;
    logic [IW-1:0]     i_q;
    logic [bitLen-1:0] m_q;
    logic [bitLen-1:0] x_q;
    logic [bitLen-1:0] e_q;
    logic [bitLen-1:0] n_q;
    logic              stop_q;
    logic [bitLen:0]   ans_q;

    logic              w_mp_start;
    logic              w_mp_done;
    logic [bitLen-1:0] w_acc;
    logic [bitLen-1:0] w_mp_a;
    logic [bitLen-1:0] w_mp_b;
    logic [bitLen-1:0] w_mp_t;

    // Next product is issued in the same cycle the previous one completes,
    // so the accumulator is taken straight from the multiplier output.
    always_comb begin
        op_d = S_SQR;
        case (state_q)
            S_SQR: begin
                if (e_q[i_q])        op_d = S_MUL;
                else if (i_q == '0)  op_d = S_CONV;
                else                 op_d = S_SQR;
            end
            S_MUL:   op_d = (i_q == '0) ? S_CONV : S_SQR;
            default: op_d = S_SQR;
        endcase
    end

    assign w_mp_start = (state_q == S_LOAD) ||
                        (w_mp_done && ((state_q == S_SQR) || (state_q == S_MUL)));
    assign w_acc      = (state_q == S_LOAD) ? x_q : w_mp_t;
    assign w_mp_a     = w_acc;
    assign w_mp_b     = (op_d == S_MUL)  ? m_q :
                        (op_d == S_CONV) ? bitLen'(1) : w_acc;

    mon_pro #(
        .bitLen (bitLen)
    ) u_mon_pro (
        .clk     (clk),
        .reset   (reset),
        .start_i (w_mp_start),
        .a_i     (w_mp_a),
        .b_i     (w_mp_b),
        .n_i     (n_q),
        .t_o     (w_mp_t),
        .done_o  (w_mp_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            m_q     <= '0;
            x_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            stop_q  <= 1'b0;
            ans_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    stop_q <= 1'b0;
                    if (start) begin
                        m_q     <= M_bar;
                        x_q     <= x_bar;
                        e_q     <= e;
                        n_q     <= n;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    i_q     <= IW'(bitLen - 1);
                    state_q <= S_SQR;
                end
                S_SQR, S_MUL: begin
                    if (w_mp_done) begin
                        state_q <= op_d;
                        if (op_d == S_SQR) i_q <= i_q - 1'b1;
                    end
                end
                S_CONV: begin
                    if (w_mp_done) begin
                        ans_q   <= {1'b0, w_mp_t};
                        stop_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        stop_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stop = stop_q;
    assign ans  = ans_q;

endmodule

`default_nettype wire

// File: tb/tb_mon_exp.sv
// ============================================================================
//  Module      : tb_mon_exp
//  Description : Self-checking bench for mon_exp against an arithmetic modpow model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mon_exp;

    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [BL-1:0] M_bar;
    logic [BL-1:0] x_bar;
    logic [BL-1:0] e;
    logic [BL-1:0] n;
    logic          stop;
    logic [BL:0]   ans;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mon_exp #(
        .bitLen (BL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .M_bar (M_bar),
        .x_bar (x_bar),
        .e     (e),
        .n     (n),
        .stop  (stop),
        .ans   (ans)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint modpow(input longint base, input longint x, input longint m);
        longint r  = 1 % m;
        longint bb = base % m;
        for (int k = 0; k < BL; k++) begin
            if (x[k]) r = (r * bb) % m;
            bb = (bb * bb) % m;
        end
        return r;
    endfunction

    function automatic int exp_latency(input longint x);
        int p = BL + 1;
        for (int k = 0; k < BL; k++) p += int'(x[k]);
        return 2 + p * (BL + 1);
    endfunction

    task automatic run_job(input logic [BL-1:0] mb, input logic [BL-1:0] xb,
                           input logic [BL-1:0] ee, input logic [BL-1:0] nn,
                           input bit toggle, output longint res, output int cyc);
        M_bar = mb; x_bar = xb; e = ee; n = nn; start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (!stop && cyc < 3000) begin
            if (toggle && cyc < 200) begin
                start = 1'($urandom_range(0, 1));
                M_bar = 16'($urandom); x_bar = 16'($urandom);
                e     = 16'($urandom); n     = 16'($urandom);
            end else begin
                start = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", longint'(stop), 1);
        res = longint'(ans);
    endtask

    task automatic end_job();
        start = 1'b0;
        @(posedge clk); #1;
        check("stop_low", longint'(stop), 0);
    endtask

    task automatic check_latency(input string tag, input int cyc, input longint ee);
        int el = exp_latency(ee);
        check(tag, (cyc >= el - 2 && cyc <= el + 2) ? el : cyc, el);
    endtask

    initial begin
        longint res;
        int     cyc;
        logic [BL-1:0] nn, mm, ee, mb, xb;

        reset = 1'b1; start = 1'b0;
        M_bar = '0; x_bar = '0; e = '0; n = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stop", longint'(stop), 0);
        check("rst_ans", longint'(ans), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_job(16'd26, 16'd157, 16'd1, 16'd589, 1'b0, res, cyc);
        check("e1_ans", res, 199);
        end_job();
        run_job(16'd26, 16'd157, 16'd2, 16'd589, 1'b0, res, cyc);
        check("e2_ans", res, 138);
        end_job();
        run_job(16'd26, 16'd157, 16'd3, 16'd589, 1'b0, res, cyc);
        check("e3_ans", res, 368);
        check_latency("e3_latency", cyc, 3);
        end_job();
        run_job(16'd26, 16'd157, 16'd0, 16'd589, 1'b0, res, cyc);
        check("e0_ans", res, 1);
        end_job();
        run_job(16'd157, 16'd157, 16'hFFFF, 16'd589, 1'b0, res, cyc);
        check("one_ans", res, 1);
        check_latency("ffff_latency", cyc, 16'hFFFF);
        end_job();
        run_job(16'd0, 16'd157, 16'd5, 16'd589, 1'b0, res, cyc);
        check("zero_base", res, 0);
        end_job();

        // Done is held while start stays high; re-raising start begins a fresh job.
        run_job(16'd26, 16'd157, 16'd2, 16'd589, 1'b0, res, cyc);
        check("hold_first", res, 138);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_stop", longint'(stop), 1);
            check("hold_ans", longint'(ans), 138);
        end
        end_job();
        run_job(16'd26, 16'd157, 16'd2, 16'd589, 1'b0, res, cyc);
        check("rerun_ans", res, 138);
        end_job();

        // Asynchronous abort mid-run.
        M_bar = 16'd26; x_bar = 16'd157; e = 16'd3; n = 16'd589; start = 1'b1;
        repeat (30) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_stop", longint'(stop), 0);
        check("abort_ans", longint'(ans), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        run_job(16'd26, 16'd157, 16'd3, 16'd589, 1'b1, res, cyc);
        check("restart_ans", res, 368);
        check_latency("toggle_latency", cyc, 3);
        end_job();

        for (int j = 0; j < 10; j++) begin
            nn = 16'($urandom_range(3, 65535)) | 16'd1;
            mm = 16'($urandom % 32'(nn));
            ee = (j % 4 == 0) ? 16'd0 : (j % 4 == 1) ? 16'hFFFF : 16'($urandom);
            mb = 16'((longint'(mm) << BL) % longint'(nn));
            xb = 16'((longint'(1) << BL) % longint'(nn));
            run_job(mb, xb, ee, nn, (j == 3), res, cyc);
            check($sformatf("rand%0d_ans", j), res, modpow(longint'(mm), longint'(ee), longint'(nn)));
            check_latency($sformatf("rand%0d_latency", j), cyc, longint'(ee));
            end_job();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
